// File: rtl/kbd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : kbd_pkg                                                |
// | Description : Shared types and constants for the PS/2 key FIFO MMIO  |
// |               block: key event record, scan-code prefixes, register  |
// |               offsets and the scan decoder state encoding.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package kbd_pkg;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       ext;   // E0-prefixed (extended) key
    logic       rel;   // F0-prefixed (break / release)
    logic [7:0] code;  // final scan-code byte
  } key_event_t;

  // Scan-code bytes with special meaning to the decoder.
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_REL    = 8'hF0;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;

  // Register offsets from the window base.
  localparam logic [31:0] REG_DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS_OFS = 32'h0000_0004;
  localparam logic [31:0] REG_CTRL_OFS   = 32'h0000_0008;

  // Scan decoder prefix-tracking states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : scan_decoder                                           |
// | Description : Assembles PS/2 scan-code byte sequences (E0 / F0       |
// |               prefixes) into key events and suppresses typematic     |
// |               repeats of the most recently pressed key.              |
// | Ports       : clk, rst (async, active-low), flush (sync clear),      |
// |               key_valid/key_code (byte in), event_out/event_valid    |
// |               (combinational, valid in the cycle of the final byte). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module scan_decoder
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output key_event_t event_out,
  output logic       event_valid
);

  dec_state_t state;
  dec_state_t state_next;

  logic       raw_done;
  key_event_t raw_ev;

  logic       held_valid;
  logic [8:0] held_key;
  logic       held_valid_next;
  logic [8:0] held_key_next;
  logic       held_match;
  logic       pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix tracking: the event is complete in the same cycle as its final byte.
  always_comb begin
    state_next  = state;
    raw_done    = 1'b0;
    raw_ev      = '0;
    raw_ev.code = key_code;
    if (key_valid) begin
      case (state)
        ST_IDLE: begin
          if (key_code == SC_EXT) begin
            state_next = ST_E0;
          end else if (key_code == SC_REL) begin
            state_next = ST_F0;
          end else if ((key_code == SC_BAT_OK) || (key_code == SC_ACK)) begin
            state_next = ST_IDLE;
          end else begin
            raw_done = 1'b1;
          end
        end
        ST_E0: begin
          if (key_code == SC_REL) begin
            state_next = ST_E0F0;
          end else begin
            raw_done   = 1'b1;
            raw_ev.ext = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_F0: begin
          raw_done   = 1'b1;
          raw_ev.rel = 1'b1;
          state_next = ST_IDLE;
        end
        ST_E0F0: begin
          raw_done   = 1'b1;
          raw_ev.ext = 1'b1;
          raw_ev.rel = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Typematic filter: a make matching the held key is an auto-repeat and is
  // dropped; the matching release ends the hold but is still reported.
  always_comb begin
    held_match      = held_valid && (held_key == {raw_ev.ext, raw_ev.code});
    pass            = 1'b0;
    held_valid_next = held_valid;
    held_key_next   = held_key;
    if (raw_done) begin
      if (raw_ev.rel) begin
        pass = 1'b1;
        if (held_match) begin
          held_valid_next = 1'b0;
        end
      end else if (!held_match) begin
        pass            = 1'b1;
        held_valid_next = 1'b1;
        held_key_next   = {raw_ev.ext, raw_ev.code};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_valid <= 1'b0;
      held_key   <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
      held_key   <= '0;
    end else begin
      held_valid <= held_valid_next;
      held_key   <= held_key_next;
    end
  end

  assign event_out   = raw_ev;
  assign event_valid = pass && !flush;

endmodule
`default_nettype wire

// File: rtl/key_fifo_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : key_fifo_mmio                                          |
// | Description : PS/2 key event FIFO with a memory-mapped CPU window    |
// |               (DATA / STATUS / CTRL) and a key-pending flag.         |
// | Ports       : clk, rst (async, active-low), key_valid/key_code from  |
// |               the PS/2 receiver, addr/wdata/we/rd_strobe from the    |
// |               CPU, rdata (combinational), key_pending (registered).  |
// | Parameters  : DEPTH (power of two, 2..16), BASE_ADDR (word aligned). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module key_fifo_mmio
  import kbd_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        rd_strobe,
  output logic [31:0] rdata,
  output logic        key_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  key_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  key_event_t dec_event;
  logic       dec_valid;

  logic sel_data;
  logic sel_status;
  logic sel_ctrl;
  logic not_empty;
  logic full;
  logic flush;
  logic pop;
  logic push;
  logic ovf_set;
  logic ovf_clr;

  logic [31:0] data_word;
  logic [31:0] status_word;
  key_event_t  head;

  // Only bits 0 (CTRL flush) and 2 (STATUS overflow clear) of store data matter.
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:3], wdata[1]};

  assign sel_data   = (addr == (BASE_ADDR + REG_DATA_OFS));
  assign sel_status = (addr == (BASE_ADDR + REG_STATUS_OFS));
  assign sel_ctrl   = (addr == (BASE_ADDR + REG_CTRL_OFS));

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);

  // Flush overrides any same-cycle push or pop.
  assign flush   = we && sel_ctrl && wdata[0];
  assign pop     = rd_strobe && sel_data && not_empty && !flush;
  // dec_valid is already suppressed by flush inside the decoder.
  assign push    = dec_valid && (!full || pop);
  assign ovf_set = dec_valid && full && !pop;
  assign ovf_clr = we && sel_status && wdata[2];

  scan_decoder u_scan_decoder (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .event_out   (dec_event),
    .event_valid (dec_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A same-cycle overflow takes priority over a software clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec_event;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    data_word = '0;
    if (not_empty) begin
      data_word[31]  = 1'b1;
      data_word[9]   = head.rel;
      data_word[8]   = head.ext;
      data_word[7:0] = head.code;
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = not_empty;
    status_word[1]    = full;
    status_word[2]    = overflow;
    status_word[12:8] = 5'(count);
  end

  always_comb begin
    rdata = '0;
    if (sel_data) begin
      rdata = data_word;
    end else if (sel_status) begin
      rdata = status_word;
    end
  end

  assign key_pending = not_empty;

endmodule
`default_nettype wire

// File: tb/tb_key_fifo_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_key_fifo_mmio                                       |
// | Description : Self-checking bench for key_fifo_mmio: queue-based     |
// |               reference model compared every cycle, plus directed    |
// |               scan-code sequences with literal expectations.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_key_fifo_mmio;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        rd_strobe;
  logic [31:0] rdata;
  logic        key_pending;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  key_fifo_mmio #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .addr        (addr),
    .wdata       (wdata),
    .we          (we),
    .rd_strobe   (rd_strobe),
    .rdata       (rdata),
    .key_pending (key_pending)
  );

  // Reference model: entries held as {rel, ext, code}, i.e. DATA bits 9:0.
  logic [9:0] m_q[$];
  logic       m_ovf;
  bit         m_ext;
  bit         m_rel;
  bit         m_held_v;
  logic [8:0] m_held;

  task automatic model_step();
    bit         flush_c;
    bit         pop_c;
    bit         clr_c;
    bit         push_req;
    bit         idle;
    logic [9:0] ev;
    flush_c  = we && (addr == BASE + 32'd8) && wdata[0];
    pop_c    = rd_strobe && (addr == BASE) && (m_q.size() != 0) && !flush_c;
    clr_c    = we && (addr == BASE + 32'd4) && wdata[2];
    push_req = 1'b0;
    ev       = '0;
    if (flush_c) begin
      m_q.delete();
      m_ext    = 1'b0;
      m_rel    = 1'b0;
      m_held_v = 1'b0;
    end else begin
      if (key_valid) begin
        idle = !m_ext && !m_rel;
        if (idle && (key_code == 8'hAA || key_code == 8'hFA)) begin
          m_ext = 1'b0;  // dropped byte, nothing changes
        end else if (idle && key_code == 8'hE0) begin
          m_ext = 1'b1;
        end else if (!m_rel && key_code == 8'hF0) begin
          m_rel = 1'b1;
        end else begin
          if (m_rel) begin
            push_req = 1'b1;
            if (m_held_v && m_held == {m_ext, key_code}) m_held_v = 1'b0;
          end else if (!(m_held_v && m_held == {m_ext, key_code})) begin
            push_req = 1'b1;
            m_held_v = 1'b1;
            m_held   = {m_ext, key_code};
          end
          ev    = {m_rel, m_ext, key_code};
          m_ext = 1'b0;
          m_rel = 1'b0;
        end
      end
      if (push_req && m_q.size() == DEPTH && !pop_c) m_ovf = 1'b1;
      else if (clr_c) m_ovf = 1'b0;
      if (pop_c) void'(m_q.pop_front());
      if (push_req && m_q.size() < DEPTH) m_q.push_back(ev);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_ext    = 1'b0;
      m_rel    = 1'b0;
      m_held_v = 1'b0;
      m_held   = '0;
    end else begin
      model_step();
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == BASE && m_q.size() != 0) begin
      r = {1'b1, 21'b0, m_q[0]};
    end else if (a == BASE + 32'd4) begin
      r[0]    = (m_q.size() != 0);
      r[1]    = (m_q.size() == DEPTH);
      r[2]    = m_ovf;
      r[12:8] = 5'(m_q.size());
    end
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    e = exp_rdata(addr);
    vectors++;
    if (rdata !== e) begin
      miscompares++;
      $display("FAIL model_rdata t=%0t addr=%h got=%h expected=%h", $time, addr, rdata, e);
    end
    vectors++;
    if (key_pending !== (m_q.size() != 0)) begin
      miscompares++;
      $display("FAIL model_pending t=%0t got=%b expected=%b", $time, key_pending, (m_q.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with arbitrary strobes, then return to quiet inputs.
  task automatic cycle(input bit kv, input logic [7:0] code, input bit w,
                       input logic [31:0] a, input logic [31:0] d, input bit rd);
    key_valid = kv;
    key_code  = code;
    we        = w;
    addr      = a;
    wdata     = d;
    rd_strobe = rd;
    tick();
    key_valid = 1'b0;
    we        = 1'b0;
    rd_strobe = 1'b0;
    wdata     = '0;
    addr      = BASE;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, BASE, 32'd0, 1'b0);
  endtask

  task automatic pop_data();
    cycle(1'b0, 8'h00, 1'b0, BASE, 32'd0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 8'h00, 1'b1, a, d, 1'b0);
  endtask

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL %s: rdata=%h required=%h", name, rdata, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = '0;
    addr      = BASE;
    wdata     = '0;
    we        = 1'b0;
    rd_strobe = 1'b0;
    tick();
    lit("rst_data", BASE, 32'h0);
    lit("rst_status", BASE + 32'd4, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Make then release of the same key.
    send(8'h1C); send(8'hF0); send(8'h1C);
    lit("make_1c", BASE, 32'h8000_001C);
    pop_data();
    lit("break_1c", BASE, 32'h8000_021C);
    pop_data();
    lit("drained", BASE, 32'h0);

    // Extended make / release; BAT byte queues nothing.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    lit("ext_make", BASE, 32'h8000_0175);
    pop_data();
    lit("ext_break", BASE, 32'h8000_0375);
    pop_data();
    send(8'hAA);
    lit("bat_dropped", BASE + 32'd4, 32'h0);

    // Typematic repeats are discarded.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    lit("typematic_cnt", BASE + 32'd4, 32'h0000_0201);
    lit("typematic_head", BASE, 32'h8000_001C);
    pop_data(); pop_data();

    // Overflow with nine distinct makes, then clear.
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    lit("overflow", BASE + 32'd4, 32'h0000_0807);
    wr(BASE + 32'd4, 32'h4);
    lit("ovf_cleared", BASE + 32'd4, 32'h0000_0803);

    // Push and pop on the same edge while full.
    cycle(1'b1, 8'h19, 1'b0, BASE, 32'd0, 1'b1);
    lit("full_pushpop_st", BASE + 32'd4, 32'h0000_0803);
    lit("full_pushpop_hd", BASE, 32'h8000_0011);

    // Flush, including a push on the flush cycle.
    wr(BASE + 32'd8, 32'h1);
    lit("flush_status", BASE + 32'd4, 32'h0);
    send(8'h30);
    cycle(1'b1, 8'h31, 1'b1, BASE + 32'd8, 32'h1, 1'b0);
    lit("flush_vs_push", BASE + 32'd4, 32'h0);

    // Overflow set wins over a same-cycle clear.
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
    cycle(1'b1, 8'h48, 1'b1, BASE + 32'd4, 32'h4, 1'b0);
    lit("set_beats_clear", BASE + 32'd4, 32'h0000_0807);
    wr(BASE + 32'd8, 32'h1);

    // Reset in the middle of an E0 sequence.
    send(8'hE0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    send(8'h75);
    lit("rst_mid_seq", BASE, 32'h8000_0075);
    send(8'h22);

    // Unmapped address and status reads have no side effects.
    wr(BASE + 32'd12, 32'h5);
    cycle(1'b0, 8'h00, 1'b0, BASE + 32'd4, 32'd0, 1'b1);
    lit("unmapped_read", BASE + 32'd12, 32'h0);
    lit("no_side_effect", BASE + 32'd4, 32'h0000_0201);
    wr(BASE + 32'd8, 32'h1);
    lit("flush_pending", BASE + 32'd4, 32'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_fifo_mmio.md
KEY_FIFO_MMIO -- requirements
Module: key_fifo_mmio

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two in 2..16.
REQ-002 Parameter BASE_ADDR, default 32'h0000_1000: word-aligned base of the register window.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 key_valid  input  1  one-cycle pulse from the PS/2 receiver, meaning key_code holds a new byte.
REQ-006 key_code  input  8  raw PS/2 scan-code byte.
REQ-007 addr  input  32  CPU data address (ALU result).
REQ-008 wdata  input  32  CPU store data.
REQ-009 we  input  1  CPU store strobe, qualified by addr.
REQ-010 rd_strobe  input  1  one-cycle CPU load strobe, qualified by addr.
REQ-011 rdata  output  32  combinational read data for addr.
REQ-012 key_pending  output  1  high while the FIFO is non-empty.

Function
REQ-013 Decoder FSM states: IDLE, E0, F0, E0F0; it SHALL advance only on cycles with key_valid=1.
REQ-014 IDLE: 0xE0 -> E0; 0xF0 -> F0; 0xAA or 0xFA -> dropped, stay IDLE; any other byte -> completes an event {ext=0, rel=0, code}.
REQ-015 E0: 0xF0 -> E0F0; any other byte -> event {ext=1, rel=0} -> IDLE.
REQ-016 F0: byte -> event {0,1,code} -> IDLE.
REQ-017 E0F0: byte -> event {1,1,code} -> IDLE.
REQ-018 Typematic filter: a 9-bit held register {ext,code} SHALL hold the last make; a make equal to held SHALL be discarded; a release equal to held SHALL clear held (valid bit 0); all other events SHALL pass.
REQ-019 A passing event SHALL be written to the FIFO on the same edge that samples its final byte; it becomes visible on rdata in the following cycle.
REQ-020 Register at BASE_ADDR+0 (DATA): bit31 = non-empty, bit9 = rel, bit8 = ext, bits7:0 = code of head entry; other bits 0; all 0 when empty.
REQ-021 Register at BASE_ADDR+4 (STATUS): bit0 non-empty, bit1 full, bit2 overflow (sticky), bits12:8 count; other bits 0.
REQ-022 Register at BASE_ADDR+8 (CTRL): reads 0.
REQ-023 Any other addr SHALL read 0 and ignore we/rd_strobe.
REQ-024 rd_strobe with addr=BASE_ADDR+0 and FIFO non-empty SHALL pop the head at that edge; when empty it SHALL have no effect.
REQ-025 Push while full and no pop: event discarded, overflow set.
REQ-026 Simultaneous push and pop when full: both performed, count unchanged, overflow not set.
REQ-027 we to STATUS with wdata bit2=1 SHALL clear overflow; if a same-cycle overflow occurs, set SHALL win.
REQ-028 we to CTRL with wdata bit0=1 SHALL flush: count 0, pointers 0, FSM to IDLE, held cleared; a same-cycle push or pop SHALL be discarded.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-030 key_pending SHALL be registered-state derived (count!=0), no combinational path from key_valid.

Reset
REQ-031 While rst=0: count, pointers and overflow 0, FSM IDLE, held cleared; rdata for DATA and STATUS reads 0; key_pending 0.
REQ-032 Reset asserted mid-sequence (e.g., after 0xE0) SHALL discard the partial sequence; FIFO contents need not be cleared, only made unreachable.

Structure
REQ-033 Package kbd_pkg SHALL hold: key_event_t struct {ext, rel, code[7:0]}, scan constants 0xE0/0xF0/0xAA/0xFA, register offsets 0/4/8, FSM state enum.
REQ-034 Sub-module scan_decoder SHALL contain the FSM and typematic filter, emitting key_event_t plus a one-cycle event_valid; FIFO and register decode stay in key_fifo_mmio.

Verification
REQ-035 Bytes 0x1C, 0xF0, 0x1C -> DATA reads 0x8000_001C then, after pop, 0x8000_021C; then 0.
REQ-036 Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> entries 0x8000_0175 and 0x8000_0375; 0xAA alone -> nothing queued.
REQ-037 Bytes 0x1C x4, then 0xF0 0x1C -> exactly two entries (make, release); repeated makes dropped.
REQ-038 Nine distinct makes with DEPTH=8, no pops -> STATUS = 0x0000_0807 (count 8, overflow, full, non-empty); STATUS write 0x4 -> 0x0000_0803.
REQ-039 Full FIFO, push and DATA pop on the same edge -> count stays 8, overflow 0, new head is second entry.
REQ-040 rst=0 asserted one cycle after 0xE0, released, then byte 0x75 -> entry 0x8000_0075 (ext=0); CTRL write 0x1 with pending entries -> STATUS 0.
